neuron_mac_seq: RTL
===================

# neuron_mac_seq

Layer sequencer for the fixed-point neural-network datapath. For each of N_OUT neurons it:
- streams N_IN inputs from the input buffer and N_IN weights from the weight ROM,
- multiply-accumulates them,
- scales and saturates the sum, then looks up the activation LUT ROM.

It sits directly upstream of the synchronous ROMs: it drives their addresses and consumes their registered q outputs, which have 1-cycle read latency. Each neuron result is emitted with a valid pulse to the downstream layer buffer.

## Interface
Parameters:
- N_IN, 8: inputs per neuron (2..8)
- N_OUT, 4: neurons per layer (1..16)
- W_ADDR_WIDTH, 5: weight ROM address width; must satisfy 2**W_ADDR_WIDTH >= N_IN*N_OUT
- X_ADDR_WIDTH, 3: input buffer address width; must satisfy 2**X_ADDR_WIDTH >= N_IN
- SHIFT, 8: arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  1-cycle pulse when the layer completes
- x_addr  out  X_ADDR_WIDTH  input buffer address
- x_data  in  8  unsigned input, valid 1 cycle after x_addr
- w_addr  out  W_ADDR_WIDTH  weight ROM address
- w_data  in  8  signed two's-complement weight, valid 1 cycle after w_addr
- lut_addr  out  8  activation LUT address (registered)
- lut_data  in  8  activation value, valid 1 cycle after lut_addr
- y_addr  out  4  neuron index of y_data
- y_data  out  8  activation result
- y_valid  out  1  1-cycle pulse; y_data and y_addr are valid

## Operation
- **States:** IDLE, MAC, DRAIN, ACT, WB.
- **IDLE:**
  - start=1 moves to MAC with neuron n=0, input index k=0, acc=0.
  - start while busy is ignored.
- **MAC (N_IN cycles):**
  - Drive x_addr=k and w_addr=n*N_IN+k.
  - From the second MAC cycle onward, acc += $signed({1'b0,x_data})*$signed(w_data). This accumulates the product for index k-1.
  - k increments; after k=N_IN-1, go to DRAIN.
- **DRAIN (1 cycle):**
  - Accumulate the last product.
  - Register lut_addr from the final sum:
    - s = (acc_final >>> SHIFT), saturated to [-128,127];
    - lut_addr = {~s[7], s[6:0]} (offset binary).
  - Go to ACT.
- **ACT (1 cycle):** Hold lut_addr while the LUT ROM registers. Go to WB.
- **WB (1 cycle):**
  - On the ending edge: y_data<=lut_data, y_addr<=n, y_valid<=1 for the following cycle.
  - If n<N_OUT-1: n++, k=0, acc=0, go to MAC.
  - Else: assert done in the following cycle and go to IDLE.
- **Arithmetic widths:**
  - Product is 17-bit signed.
  - acc is 20-bit signed; it never overflows for N_IN<=8.
  - Saturation is applied only after the shift.
- **Address outputs outside MAC:** x_addr and w_addr hold their last value; their content is don't-care.

## Timing
- **Reset values:** All outputs are 0: busy, done, y_valid, y_data, y_addr, lut_addr, x_addr, w_addr. State is IDLE, acc=0.
- **Reset mid-operation:** Immediately abandons the layer. No y_valid or done is emitted afterwards.
- **Per-neuron period:** N_IN+3 cycles.
- **Cycle numbering:** Edge E0 samples start. Then:
  - MAC occupies cycles 1..N_IN;
  - DRAIN is N_IN+1, ACT is N_IN+2, WB is N_IN+3;
  - y_valid for n=0 is in cycle N_IN+4, overlapping MAC k=0 of n=1.
- **Last result:** y_valid and done are both high in cycle N_OUT*(N_IN+3)+1. busy is low in that same cycle.
- **Back-to-back layers:** start is accepted in the done cycle, so layers can run back-to-back.
- **Stability:** y_data and y_addr hold until the next y_valid.
- **No backpressure:** The downstream layer buffer must accept every y_valid.

## Test plan
All scenarios use defaults and an identity LUT (lut[a]=a), so y_data equals lut_addr.

- **Positive saturation:** All x=255, all w=127 → sum 259080 → shifted 1012 → saturated 127 → y_data=255 for all 4 neurons; y_addr 0,1,2,3; done at cycle 45.
- **Negative saturation:** All x=255, all w=-128 (0x80) → sum -261120 → y_data=0.
- **Zero weights:** All w=0 → y_data=128. Also set x=16, w=16 for neuron 2 only → sum 2048 → s=8 → y_data=136 on y_addr=2.
- **Addressing check:** Mixed x_k=k+1 and w=+1/-1 alternating per k. Check w_addr sequence 0..31 and x_addr sequence 0..7 repeated, and that each y_valid is exactly 1 cycle wide, spaced every 11 cycles.
- **Reset mid-operation:** Assert rst_n low during the ACT state of neuron 1 → all outputs 0 immediately, no further y_valid/done. A new start after release produces the full 4-result sequence.
- **start handling:** start held high throughout is ignored while busy. Pulsing start in the done cycle starts the next layer without gap; the first w_addr=0 appears in the following cycle.

Source files
------------

// File: rtl/neuron_mac_seq_if.sv
// Handshake and memory-port bundle between the layer sequencer and its
// input buffer, weight ROM, activation LUT and downstream layer buffer.
interface neuron_mac_seq_if #(
  parameter int X_ADDR_WIDTH = 3,
  parameter int W_ADDR_WIDTH = 5
) ();
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [X_ADDR_WIDTH-1:0] x_addr;
  logic [7:0]              x_data;
  logic [W_ADDR_WIDTH-1:0] w_addr;
  logic [7:0]              w_data;
  logic [7:0]              lut_addr;
  logic [7:0]              lut_data;
  logic [3:0]              y_addr;
  logic [7:0]              y_data;
  logic                    y_valid;

  modport master (
    input  start, x_data, w_data, lut_data,
    output busy, done, x_addr, w_addr, lut_addr, y_addr, y_data, y_valid
  );

  modport slave (
    output start, x_data, w_data, lut_data,
    input  busy, done, x_addr, w_addr, lut_addr, y_addr, y_data, y_valid
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// Layer sequencer: per neuron, MAC over N_IN input/weight pairs read from
// 1-cycle-latency ROMs, shift+saturate, activation LUT lookup, emit result.
module neuron_mac_seq #(
  parameter int N_IN         = 8,
  parameter int N_OUT        = 4,
  parameter int W_ADDR_WIDTH = 5,
  parameter int X_ADDR_WIDTH = 3,
  parameter int SHIFT        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  neuron_mac_seq_if.master   bus
);

  localparam int DATA_W  = 8;
  localparam int PROD_W  = 17;
  localparam int ACC_W   = 20;
  localparam logic [X_ADDR_WIDTH-1:0] K_LAST = X_ADDR_WIDTH'(N_IN - 1);
  localparam logic [3:0]              N_LAST = 4'(N_OUT - 1);

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, ACT, WB} state_t;

  state_t                    state, state_nxt;
  logic [X_ADDR_WIDTH-1:0]   k;
  logic [W_ADDR_WIDTH-1:0]   w_ptr;
  logic [3:0]                n;
  logic signed [ACC_W-1:0]   acc;
  logic [DATA_W-1:0]         lut_addr_r;
  logic [DATA_W-1:0]         y_data_r;
  logic [3:0]                y_addr_r;
  logic                      y_valid_r;
  logic                      done_r;

  logic signed [PROD_W-1:0]  x_ext, w_ext, prod_p0;
  logic signed [ACC_W-1:0]   acc_sum;

  // Shift, clamp to the signed 8-bit range, then flip the sign bit so the
  // LUT is indexed in offset binary (-128 -> 0, 0 -> 128, 127 -> 255).
  function automatic logic [DATA_W-1:0] to_lut_addr(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [DATA_W-1:0]       q;
    s = a >>> SHIFT;
    if (s > ACC_W'(127))       q = 8'h7f;
    else if (s < ACC_W'(-128)) q = 8'h80;
    else                       q = s[DATA_W-1:0];
    return {~q[DATA_W-1], q[DATA_W-2:0]};
  endfunction

  // Stage p0: product of the ROM outputs addressed in the previous cycle
  assign x_ext   = {{(PROD_W-DATA_W){1'b0}}, bus.x_data};
  assign w_ext   = {{(PROD_W-DATA_W){bus.w_data[DATA_W-1]}}, bus.w_data};
  assign prod_p0 = x_ext * w_ext;
  assign acc_sum = acc + ACC_W'(prod_p0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = MAC;
      MAC:     if (k == K_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = ACT;
      ACT:     state_nxt = WB;
      WB:      state_nxt = (n == N_LAST) ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      w_ptr      <= '0;
      n          <= '0;
      acc        <= '0;
      lut_addr_r <= '0;
      y_data_r   <= '0;
      y_addr_r   <= '0;
      y_valid_r  <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      y_valid_r <= 1'b0;
      done_r    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            k     <= '0;
            w_ptr <= '0;
            n     <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          // Data for index k-1 arrives now; nothing is valid on the first cycle
          if (k != '0) acc <= acc_sum;
          if (k != K_LAST) begin
            k     <= k + 1'b1;
            w_ptr <= w_ptr + 1'b1;
          end
        end
        DRAIN: begin
          acc        <= acc_sum;
          lut_addr_r <= to_lut_addr(acc_sum);
        end
        ACT: ;
        WB: begin
          y_data_r  <= bus.lut_data;
          y_addr_r  <= n;
          y_valid_r <= 1'b1;
          if (n == N_LAST) begin
            done_r <= 1'b1;
          end else begin
            n     <= n + 1'b1;
            k     <= '0;
            acc   <= '0;
            w_ptr <= w_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.x_addr   = k;
  assign bus.w_addr   = w_ptr;
  assign bus.lut_addr = lut_addr_r;
  assign bus.y_addr   = y_addr_r;
  assign bus.y_data   = y_data_r;
  assign bus.y_valid  = y_valid_r;

endmodule
